pe_feeder: RTL and testbench
============================

# pe_feeder

Operand sequencer that drives one multiply-accumulate PE. An upstream loader writes (ifmap, filter) byte pairs into a local buffer. The block then clears the PE accumulator, streams one pair per cycle into the PE with `pe_en`, captures the PE's 8-bit psum and returns it on a valid/ready result port. It sits between the array-level scheduler and each PE and is the driving end of the PE's operand/enable interface.

## Interface
- `DEPTH`, 16, maximum pairs per dot product (power of two, ≥2)
- `DATA_W`, 8, operand and psum width

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- `ld_valid`  in  1  loader offers a pair
- `ld_ready`  out  1  block accepts the pair this cycle
- `ld_ifmap`  in  DATA_W  ifmap operand
- `ld_filter`  in  DATA_W  filter operand
- `ld_last`  in  1  marks the final pair of the vector
- `pe_clr`  out  1  one-cycle accumulator clear to the PE
- `pe_en`  out  1  PE accumulate enable
- `pe_ifmap`  out  DATA_W  operand to the PE
- `pe_filter`  out  DATA_W  operand to the PE
- `pe_psum`  in  DATA_W  PE accumulator output
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer takes the result
- `res_data`  out  DATA_W  captured psum
- `res_macs`  out  $clog2(DEPTH+1)  number of `pe_en` beats issued

## Operation
- FSM: LOAD → CLEAR → STREAM → DRAIN → RESULT → LOAD.
- LOAD:
  - `ld_ready`=1.
  - Each `ld_valid && ld_ready` writes `buf[wr_ptr]` and increments `wr_ptr`.
  - Go to CLEAR when the accepted pair has `ld_last`=1, or when it is the DEPTH-th pair (forced last).
  - N = number of pairs accepted, 1..DEPTH.
- CLEAR:
  - `pe_clr`=1 and `pe_en`=0 for exactly one cycle.
  - `rd_ptr`←0 and `res_macs`←0.
- STREAM:
  - Each cycle drives `pe_ifmap`/`pe_filter`=`buf[rd_ptr]` with `pe_en`=1, and `res_macs`++.
  - Leave for DRAIN after entry N-1.
- DRAIN: `pe_en`=0 for one cycle, which lets the PE accumulator register the last product. `res_data`←`pe_psum` at the end of DRAIN.
- RESULT:
  - `res_valid`=1. `res_data` and `res_macs` are held stable until `res_ready`.
  - On handshake go to LOAD with `wr_ptr`←0.
- `ld_ready`=0 in every state except LOAD. `ld_*` inputs are ignored outside LOAD.
- Arithmetic: no arithmetic inside the block. `res_data` is the PE's modulo-256 psum, passed through unmodified.
- Pointer wrap: `wr_ptr`/`rd_ptr` never wrap within a vector. The DEPTH-th write forces the end of the load.
- Simultaneous events:
  - `res_ready` held high before `res_valid` completes the handshake in RESULT's first cycle.
  - `ld_valid` asserted during RESULT is not accepted until the cycle after the handshake.
- Reset, including mid-operation (asynchronous):
  - State→LOAD, `wr_ptr`=`rd_ptr`=0.
  - Outputs reset to `ld_ready`=1, `pe_clr`=0, `pe_en`=0, `pe_ifmap`=`pe_filter`=0, `res_valid`=0, `res_data`=0, `res_macs`=0.
  - Buffer contents are not reset.
  - The PE shares `rst`, so it needs no `pe_clr` during reset.

## Timing
- All `pe_*`, `res_*` and `ld_ready` outputs are registered.
- Let the `ld_last` handshake occur in cycle T:
  - CLEAR in T+1.
  - STREAM in T+2 … T+1+N.
  - DRAIN in T+2+N.
  - `res_valid` first high in T+3+N.
- After the result handshake in cycle R, `ld_ready`=1 in R+1.
- Minimum spacing between successive vectors: N+4 cycles plus the load time.
- PE contract: `pe_psum` reflects every accepted `pe_en` beat one cycle after that beat. `pe_clr` takes effect by the next cycle.

## Configuration
- `PE_FEEDER_ZSKIP_EN` defined (zero-skip for power):
  - A STREAM entry with either operand 0 still takes its cycle.
  - For that entry, `pe_en`=0, `pe_ifmap`/`pe_filter` hold their previous values, and `res_macs` is not incremented.
  - Latency is unchanged.
- Macro undefined: every entry drives `pe_en`=1, so `res_macs`=N always.

## Structure
- Shared package `pe_pkg`:
  - `DATA_W` constant.
  - State enum type `feeder_state_t` (LOAD, CLEAR, STREAM, DRAIN, RESULT).
  - Operand-pair struct (ifmap, filter).
- Sub-module `pe_feeder_buf`: DEPTH × 2·DATA_W register file with one synchronous write port and one combinational read port. No reset on its storage.

## Test plan
- Three pairs (2,3), (4,5), (1,7), `ld_last` on the third → `pe_en` high exactly 3 consecutive cycles with those operands; the PE model gives `res_data`=33, `res_macs`=3, and `res_valid` rises 6 cycles after the `ld_last` handshake.
- Two pairs (200,1), (100,1) → `res_data`=44 (300 mod 256). A single pair (9,9) with `ld_last` → `res_data`=81, `res_valid` at T+4.
- 16 pairs (1,1), no `ld_last` → `ld_ready` drops the cycle after the 16th handshake; 16 `pe_en` beats; `res_data`=16, `res_macs`=16.
- Hold `res_ready`=0 for 5 cycles after `res_valid` → `res_valid`/`res_data` held stable and `ld_ready`=0 throughout; raise `res_ready` → `ld_ready`=1 the next cycle.
- Assert `rst` for 1 cycle mid-STREAM → `pe_en`, `res_valid` and `res_macs` go 0 immediately and `ld_ready`=1. A new vector (3,4) afterwards → `res_data`=12.
- Pairs (0,9), (3,3), (5,0) → with `PE_FEEDER_ZSKIP_EN`: `pe_en` high for 1 of 3 STREAM cycles, `res_macs`=1, `res_data`=9. Without the macro: `res_macs`=3, `res_data`=9.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE operand feeder.
package pe_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_CLEAR,
      ST_STREAM,
      ST_DRAIN,
      ST_RESULT
   } feeder_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] ifmap;
      logic [DATA_W-1:0] filter;
   } operand_pair_t;

endpackage

// File: rtl/pe_feeder_buf.sv
// Operand-pair register file: one synchronous write port, one combinational read port.
// Storage is deliberately left without reset.
module pe_feeder_buf
   import pe_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 2 * DATA_W
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_feeder.sv
// Operand sequencer for one MAC PE: load pairs, clear PE, stream pairs, capture psum.
// Optional zero-skip (pe_en suppressed on zero operands) enabled by PE_FEEDER_ZSKIP_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LOAD   | accept (ifmap, filter) pairs until ld_last or buffer full
// ST_CLEAR  | one-cycle pe_clr to the PE accumulator
// ST_STREAM | one buffer entry per cycle toward the PE
// ST_DRAIN  | idle cycle so the PE registers the last product
// ST_RESULT | psum and beat count offered on the result port
module pe_feeder #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = pe_pkg::DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [DATA_W-1:0]          ld_ifmap,
   input  logic [DATA_W-1:0]          ld_filter,
   input  logic                       ld_last,
   output logic                       pe_clr,
   output logic                       pe_en,
   output logic [DATA_W-1:0]          pe_ifmap,
   output logic [DATA_W-1:0]          pe_filter,
   input  logic [DATA_W-1:0]          pe_psum,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [DATA_W-1:0]          res_data,
   output logic [$clog2(DEPTH+1)-1:0] res_macs
);

   import pe_pkg::*;

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int MACS_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(DEPTH-1);

   feeder_state_t state, state_d;

   logic [PTR_W-1:0]    wr_ptr, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr, rd_ptr_d;
   logic [PTR_W-1:0]    last_ptr, last_ptr_d;
   logic [PTR_W-1:0]    rd_addr;
   logic                wr_en;
   logic [2*DATA_W-1:0] rd_data;
   logic [DATA_W-1:0]   rd_ifmap, rd_filter;
   logic                issue;

   logic                ld_ready_d, pe_clr_d, pe_en_d, res_valid_d;
   logic [DATA_W-1:0]   pe_ifmap_d, pe_filter_d, res_data_d;
   logic [MACS_W-1:0]   res_macs_d;

   assign wr_en = (state == ST_LOAD) && ld_valid && ld_ready;

   // Outputs are registered, so the read port looks one entry ahead of rd_ptr.
   assign rd_addr = (state == ST_CLEAR) ? '0 : rd_ptr + PTR_W'(1);
   assign {rd_ifmap, rd_filter} = rd_data;

`ifdef PE_FEEDER_ZSKIP_EN
   assign issue = (rd_ifmap != '0) && (rd_filter != '0);
`else
   assign issue = 1'b1;
`endif

   pe_feeder_buf #(
      .DEPTH (DEPTH),
      .WIDTH (2*DATA_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data ({ld_ifmap, ld_filter}),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d     = state;
      wr_ptr_d    = wr_ptr;
      rd_ptr_d    = rd_ptr;
      last_ptr_d  = last_ptr;
      ld_ready_d  = ld_ready;
      pe_clr_d    = 1'b0;
      pe_en_d     = 1'b0;
      pe_ifmap_d  = pe_ifmap;
      pe_filter_d = pe_filter;
      res_valid_d = res_valid;
      res_data_d  = res_data;
      res_macs_d  = res_macs;

      case (state)
         ST_LOAD: begin
            if (ld_valid && ld_ready) begin
               wr_ptr_d = wr_ptr + PTR_W'(1);
               if (ld_last || (wr_ptr == FULL_PTR)) begin
                  state_d    = ST_CLEAR;
                  last_ptr_d = wr_ptr;
                  ld_ready_d = 1'b0;
                  pe_clr_d   = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            state_d    = ST_STREAM;
            rd_ptr_d   = '0;
            res_macs_d = '0;
            pe_en_d    = issue;
            if (issue) begin
               pe_ifmap_d  = rd_ifmap;
               pe_filter_d = rd_filter;
            end
         end
         ST_STREAM: begin
            if (pe_en) begin
               res_macs_d = res_macs + MACS_W'(1);
            end
            if (rd_ptr == last_ptr) begin
               state_d = ST_DRAIN;
            end else begin
               rd_ptr_d = rd_ptr + PTR_W'(1);
               pe_en_d  = issue;
               if (issue) begin
                  pe_ifmap_d  = rd_ifmap;
                  pe_filter_d = rd_filter;
               end
            end
         end
         ST_DRAIN: begin
            state_d     = ST_RESULT;
            res_data_d  = pe_psum;
            res_valid_d = 1'b1;
         end
         ST_RESULT: begin
            if (res_ready) begin
               state_d     = ST_LOAD;
               res_valid_d = 1'b0;
               ld_ready_d  = 1'b1;
               wr_ptr_d    = '0;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_LOAD;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         last_ptr  <= '0;
         ld_ready  <= 1'b1;
         pe_clr    <= 1'b0;
         pe_en     <= 1'b0;
         pe_ifmap  <= '0;
         pe_filter <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_macs  <= '0;
      end else begin
         state     <= state_d;
         wr_ptr    <= wr_ptr_d;
         rd_ptr    <= rd_ptr_d;
         last_ptr  <= last_ptr_d;
         ld_ready  <= ld_ready_d;
         pe_clr    <= pe_clr_d;
         pe_en     <= pe_en_d;
         pe_ifmap  <= pe_ifmap_d;
         pe_filter <= pe_filter_d;
         res_valid <= res_valid_d;
         res_data  <= res_data_d;
         res_macs  <= res_macs_d;
      end
   end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder with a behavioural PE and a dot-product reference model.
module tb_pe_feeder;

   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int MW    = $clog2(DEPTH+1);
`ifdef PE_FEEDER_ZSKIP_EN
   localparam bit ZSKIP = 1'b1;
`else
   localparam bit ZSKIP = 1'b0;
`endif

   logic          clk, rst;
   logic          ld_valid, ld_ready, ld_last;
   logic [DW-1:0] ld_ifmap, ld_filter;
   logic          pe_clr, pe_en;
   logic [DW-1:0] pe_ifmap, pe_filter, pe_psum;
   logic          res_valid, res_ready;
   logic [DW-1:0] res_data;
   logic [MW-1:0] res_macs;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [DW-1:0] acc;
   logic [DW-1:0] vi [DEPTH];
   logic [DW-1:0] vf [DEPTH];
   logic [15:0]   beat_q [$];
   int            beat_cyc [$];
   int            clr_cyc;
   int            hs_t;
   int            lat;
   logic [DW-1:0] r_data;
   logic [MW-1:0] r_macs;

   pe_feeder #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_ifmap  (ld_ifmap),
      .ld_filter (ld_filter),
      .ld_last   (ld_last),
      .pe_clr    (pe_clr),
      .pe_en     (pe_en),
      .pe_ifmap  (pe_ifmap),
      .pe_filter (pe_filter),
      .pe_psum   (pe_psum),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_macs  (res_macs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // PE: 8-bit accumulator, product visible one cycle after its pe_en beat.
   always @(posedge clk or posedge rst) begin
      if (rst)         acc <= '0;
      else if (pe_clr) acc <= '0;
      else if (pe_en)  acc <= acc + pe_ifmap * pe_filter;
   end
   assign pe_psum = acc;

   always @(negedge clk) begin
      if (!rst) begin
         if (pe_en) begin
            beat_q.push_back({pe_ifmap, pe_filter});
            beat_cyc.push_back(cyc);
         end
         if (pe_clr) clr_cyc = cyc;
      end
   end

   function automatic int model_psum(input int n);
      int s = 0;
      for (int k = 0; k < n; k++) s += int'(vi[k]) * int'(vf[k]);
      return s % 256;
   endfunction

   function automatic int model_macs(input int n);
      int m = 0;
      for (int k = 0; k < n; k++)
         if (!ZSKIP || (vi[k] != 0 && vf[k] != 0)) m++;
      return m;
   endfunction

   task automatic drive_vector(input int n, input bit use_last, output bit ok);
      int i = 0;
      int guard = 0;
      beat_q.delete();
      beat_cyc.delete();
      clr_cyc = -1;
      while (i < n && guard < 200) begin
         @(negedge clk);
         guard++;
         ld_valid  = 1'b1;
         ld_ifmap  = vi[i];
         ld_filter = vf[i];
         ld_last   = use_last && (i == n-1);
         if (ld_ready) begin
            hs_t = cyc;
            i++;
         end
      end
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ok = (i == n);
   endtask

   task automatic wait_result(output bit ok);
      int guard = 0;
      while (guard < 100) begin
         if (res_valid) break;
         @(negedge clk);
         guard++;
      end
      ok     = res_valid;
      lat    = cyc - hs_t;
      r_data = res_data;
      r_macs = res_macs;
   endtask

   task automatic pop_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({ld_ready, pe_clr, pe_en, pe_ifmap, pe_filter, res_valid, res_data, res_macs}
          !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 5'd0}) begin
         errors++;
         $display("FAIL reset_outputs: ld_ready=%b pe_clr=%b pe_en=%b ifm=%0d fil=%0d rv=%b rd=%0d rm=%0d, want 1 0 0 0 0 0 0 0",
                  ld_ready, pe_clr, pe_en, pe_ifmap, pe_filter, res_valid, res_data, res_macs);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_three_pairs();
      bit ok;
      vi[0] = 2; vf[0] = 3; vi[1] = 4; vf[1] = 5; vi[2] = 1; vf[2] = 7;
      drive_vector(3, 1'b1, ok);
      wait_result(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL three_timeout: res_valid=%b want 1", res_valid); end
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL three_latency: got %0d want 6", lat); end
      checks++;
      if (r_data !== 8'd33) begin errors++; $display("FAIL three_data: got %0d want 33", r_data); end
      checks++;
      if (r_macs !== 5'd3) begin errors++; $display("FAIL three_macs: got %0d want 3", r_macs); end
      checks++;
      if (clr_cyc !== hs_t + 1) begin errors++; $display("FAIL three_clr_cycle: got %0d want %0d", clr_cyc, hs_t + 1); end
      checks++;
      if (beat_q.size() !== 3) begin
         errors++; $display("FAIL three_beat_count: got %0d want 3", beat_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (beat_q[k] !== {vi[k], vf[k]} || beat_cyc[k] !== hs_t + 2 + k) begin
               errors++;
               $display("FAIL three_beat%0d: got %h@%0d want %h@%0d", k, beat_q[k], beat_cyc[k], {vi[k], vf[k]}, hs_t + 2 + k);
            end
         end
      end
      pop_result();
      checks++;
      if (ld_ready !== 1'b1 || res_valid !== 1'b0) begin
         errors++; $display("FAIL three_after_pop: ld_ready=%b res_valid=%b want 1 0", ld_ready, res_valid);
      end
   endtask

   task automatic test_modulo_and_single();
      bit ok;
      vi[0] = 200; vf[0] = 1; vi[1] = 100; vf[1] = 1;
      res_ready = 1'b1;
      drive_vector(2, 1'b1, ok);
      wait_result(ok);
      checks++;
      if (!ok || r_data !== 8'd44) begin errors++; $display("FAIL modulo_data: got %0d want 44", r_data); end
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || ld_ready !== 1'b1) begin
         errors++; $display("FAIL early_ready_handshake: res_valid=%b ld_ready=%b want 0 1", res_valid, ld_ready);
      end
      vi[0] = 9; vf[0] = 9;
      drive_vector(1, 1'b1, ok);
      wait_result(ok);
      checks++;
      if (!ok || lat !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", lat); end
      checks++;
      if (r_data !== 8'd81 || r_macs !== 5'd1) begin
         errors++; $display("FAIL single_result: data=%0d macs=%0d want 81 1", r_data, r_macs);
      end
      pop_result();
   endtask

   task automatic test_full_depth();
      bit ok;
      for (int k = 0; k < DEPTH; k++) begin vi[k] = 1; vf[k] = 1; end
      drive_vector(DEPTH, 1'b0, ok);
      checks++;
      if (!ok || ld_ready !== 1'b0) begin errors++; $display("FAIL full_ld_ready: got %b want 0", ld_ready); end
      wait_result(ok);
      checks++;
      if (beat_q.size() !== DEPTH) begin errors++; $display("FAIL full_beats: got %0d want 16", beat_q.size()); end
      checks++;
      if (!ok || r_data !== 8'd16 || r_macs !== 5'd16) begin
         errors++; $display("FAIL full_result: data=%0d macs=%0d want 16 16", r_data, r_macs);
      end
      checks++;
      if (lat !== DEPTH + 3) begin errors++; $display("FAIL full_latency: got %0d want %0d", lat, DEPTH + 3); end
      pop_result();
   endtask

   task automatic test_backpressure();
      bit ok;
      vi[0] = 8'($urandom_range(1, 255)); vf[0] = 8'($urandom_range(1, 255));
      vi[1] = 8'($urandom_range(1, 255)); vf[1] = 8'($urandom_range(1, 255));
      drive_vector(2, 1'b1, ok);
      wait_result(ok);
      checks++;
      if (!ok || r_data !== 8'(model_psum(2))) begin
         errors++; $display("FAIL bp_data: got %0d want %0d", r_data, model_psum(2));
      end
      ld_valid = 1'b1; ld_ifmap = 8'hAA; ld_filter = 8'h55;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_data !== r_data || res_macs !== r_macs || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: rv=%b rd=%0d rm=%0d ldr=%b want 1 %0d %0d 0", c, res_valid, res_data, res_macs, ld_ready, r_data, r_macs);
         end
      end
      ld_valid = 1'b0;
      pop_result();
      checks++;
      if (ld_ready !== 1'b1) begin errors++; $display("FAIL bp_release: ld_ready=%b want 1", ld_ready); end
   endtask

   task automatic test_mid_reset();
      bit ok;
      int guard = 0;
      for (int k = 0; k < 8; k++) begin
         vi[k] = 8'($urandom_range(1, 255)); vf[k] = 8'($urandom_range(1, 255));
      end
      drive_vector(8, 1'b1, ok);
      while (!pe_en && guard < 10) begin @(negedge clk); guard++; end
      @(negedge clk);
      checks++;
      if (pe_en !== 1'b1) begin errors++; $display("FAIL midrst_stream: pe_en=%b want 1", pe_en); end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (pe_en !== 1'b0 || res_valid !== 1'b0 || res_macs !== '0 || ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_outputs: pe_en=%b rv=%b rm=%0d ldr=%b want 0 0 0 1", pe_en, res_valid, res_macs, ld_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      vi[0] = 3; vf[0] = 4;
      drive_vector(1, 1'b1, ok);
      wait_result(ok);
      checks++;
      if (!ok || r_data !== 8'd12 || r_macs !== 5'd1) begin
         errors++; $display("FAIL midrst_recover: data=%0d macs=%0d want 12 1", r_data, r_macs);
      end
      pop_result();
   endtask

   task automatic test_zero_skip();
      bit ok;
      vi[0] = 0; vf[0] = 9; vi[1] = 3; vf[1] = 3; vi[2] = 5; vf[2] = 0;
      drive_vector(3, 1'b1, ok);
      wait_result(ok);
      checks++;
      if (!ok || r_data !== 8'd9) begin errors++; $display("FAIL zskip_data: got %0d want 9", r_data); end
      checks++;
      if (r_macs !== MW'(ZSKIP ? 1 : 3)) begin
         errors++; $display("FAIL zskip_macs: got %0d want %0d", r_macs, ZSKIP ? 1 : 3);
      end
      checks++;
      if (beat_q.size() !== (ZSKIP ? 1 : 3)) begin
         errors++; $display("FAIL zskip_beats: got %0d want %0d", beat_q.size(), ZSKIP ? 1 : 3);
      end
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL zskip_latency: got %0d want 6", lat); end
      pop_result();
   endtask

   task automatic test_random();
      bit ok;
      bit use_last;
      int n;
      logic [15:0] exp_b [$];
      int exp_c [$];
      for (int v = 0; v < 6; v++) begin
         n = $urandom_range(1, DEPTH);
         use_last = (n == DEPTH) ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int k = 0; k < n; k++) begin
            vi[k] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            vf[k] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         end
         exp_b.delete();
         exp_c.delete();
         drive_vector(n, use_last, ok);
         for (int k = 0; k < n; k++) begin
            if (!ZSKIP || (vi[k] != 0 && vf[k] != 0)) begin
               exp_b.push_back({vi[k], vf[k]});
               exp_c.push_back(hs_t + 2 + k);
            end
         end
         wait_result(ok);
         checks++;
         if (!ok || lat !== n + 3) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", v, lat, n + 3); end
         checks++;
         if (r_data !== 8'(model_psum(n)) || r_macs !== MW'(model_macs(n))) begin
            errors++;
            $display("FAIL rand%0d_result: data=%0d macs=%0d want %0d %0d", v, r_data, r_macs, model_psum(n), model_macs(n));
         end
         checks++;
         if (beat_q.size() !== exp_b.size()) begin
            errors++; $display("FAIL rand%0d_beats: got %0d want %0d", v, beat_q.size(), exp_b.size());
         end else begin
            for (int k = 0; k < exp_b.size(); k++) begin
               checks++;
               if (beat_q[k] !== exp_b[k] || beat_cyc[k] !== exp_c[k]) begin
                  errors++;
                  $display("FAIL rand%0d_beat%0d: got %h@%0d want %h@%0d", v, k, beat_q[k], beat_cyc[k], exp_b[k], exp_c[k]);
               end
            end
         end
         pop_result();
      end
   endtask

   initial begin
      rst       = 1'b1;
      ld_valid  = 1'b0;
      ld_ifmap  = '0;
      ld_filter = '0;
      ld_last   = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_three_pairs();
      test_modulo_and_single();
      test_full_depth();
      test_backpressure();
      test_mid_reset();
      test_zero_skip();
      test_random();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, want completion");
      $fatal(1, "timeout");
   end

endmodule
